// File: rtl/pipe_stage_chain.sv
// Chain of STAGES elastic pipeline registers with valid/ready back-pressure,
// global stall, full flush, per-stage kill and registered occupancy.
module pipe_stage_chain #(
  parameter int                WIDTH      = 64,
  parameter int                STAGES     = 4,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [STAGES-1:0]            flush_mask,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [OCC_W-1:0]  occ_q;

  logic [STAGES-1:0] ev;
  logic [STAGES:0]   r;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic              in_xfer;

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++) cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  // Ready ripples back from out_ready: a stage can take data if it is
  // empty (or being killed) or its own content moves on this cycle.
  always_comb begin
    ev         = v_q & ~flush_mask & {STAGES{~flush}};
    r          = '0;
    r[STAGES]  = out_ready;
    for (int i = STAGES-1; i >= 0; i--) r[i] = ~ev[i] | r[i+1];
  end

  assign in_ready  = r[0] & ~stall & ~flush & ~rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = ev[STAGES-1] & ~stall;
  assign out_data  = d_q[STAGES-1];

  always_comb begin
    src_v    = '0;
    src_v[0] = in_xfer;
    src_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = ev[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  // Priority: flush, then stall (still honouring flush_mask), then movement.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else if (stall) begin
      v_d = v_q & ~flush_mask;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (r[i]) begin
          if (src_v[i]) begin
            v_d[i] = 1'b1;
            d_d[i] = src_d[i];
          end else begin
            v_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < STAGES; i++) d_q[i] <= RESET_DATA;
    end else begin
      v_q   <= v_d;
      occ_q <= popcount(v_d);
      for (int i = 0; i < STAGES; i++) d_q[i] <= d_d[i];
    end
  end

  always_comb begin
    stage_data = '0;
    for (int i = 0; i < STAGES; i++) stage_data[i*WIDTH +: WIDTH] = d_q[i];
  end

  assign stage_valid = v_q;
  assign occupancy   = occ_q;

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed always-load pipeline registers between CPU stages.
- Builds a chain of STAGES elastic pipeline registers, each WIDTH bits with its own valid bit.
- Adds valid/ready back-pressure, global stall, full flush, per-stage kill (flush_mask) and occupancy visibility for hazard logic.
- Intended to replace the IF/ID..MEM/WB register chain once hazard/branch handling is added.

Parameters:
- WIDTH, 64, payload bits per stage (>=1)
- STAGES, 4, number of register stages (>=1)
- RESET_DATA, 0, value loaded into every stage data register on reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  payload into stage 0
- out_valid  out  1  stage STAGES-1 presents out_data
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH  payload of stage STAGES-1
- stall  in  1  freeze all stages this cycle
- flush  in  1  kill every stage this cycle
- flush_mask  in  STAGES  kill selected stages this cycle (bit i = stage i)
- stage_valid  out  STAGES  valid bit of each stage (registered)
- stage_data  out  STAGES*WIDTH  flattened stage payloads, stage i at [i*WIDTH +: WIDTH]
- occupancy  out  $clog2(STAGES+1)  number of valid stages (registered)

Behaviour:
- Reset (async, immediate): all valid=0, all data=RESET_DATA, occupancy=0, out_valid=0, stage_valid=0. in_ready is 0 while rst is high.
- Per-stage state: v[i], d[i].
- Effective valid: ev[i] = v[i] & ~flush_mask[i] & ~flush.
- Ready chain:
  - r[STAGES] = out_ready
  - r[i] = ~ev[i] | r[i+1]
  - This path is combinational from out_ready to in_ready; accepted by design.
- Handshake outputs:
  - in_ready = r[0] & ~stall & ~flush
  - out_valid = ev[STAGES-1] & ~stall
  - out_data = d[STAGES-1]
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Priority per cycle: flush > flush_mask > stall > normal movement.
- flush=1: next edge, all v=0. Input is not accepted; no output transfer. Data registers hold.
- flush_mask[i]=1 (flush=0): next edge, v[i]=0 unless stage i is loaded from stage i-1 (or from input if i=0) in the same cycle. A killed entry never moves downstream and never appears on out_valid. Stage i can still receive new data that same cycle, since ev[i]=0 makes r[i]=1.
- stall=1 (no flush): no stage changes valid or data; in_ready=0, out_valid=0. flush_mask is still honoured during stall (killed bits clear, nothing moves).
- Normal movement: stage i loads when r[i]=1 and the source is valid.
  - Source for i>0 is ev[i-1]; source for stage 0 is in_valid & in_ready.
  - On load: d[i] <= source data, v[i] <= 1.
  - Stage i with r[i]=1 and no valid source: v[i] <= 0, d[i] holds.
  - Stage i with r[i]=0: holds.
- Bubbles collapse: a valid entry advances into an empty stage even when out_ready=0.
- Latency: accept to out_valid = STAGES cycles through an empty chain. Throughput is 1 item/cycle with out_ready=1.
- Full: all v=1 and out_ready=0 gives in_ready=0. If out_ready=1 while full, in_ready=1 in the same cycle (pass-through).
- occupancy = popcount of next-state v, registered. It is always equal to popcount(stage_valid).
- Ordering: items exit in acceptance order. No duplication; no loss except by flush or flush_mask.
- Reset asserted mid-stream discards all contents immediately. The first accept is possible on the first edge after rst deasserts.

Test Plan:
- STAGES=4, WIDTH=8, out_ready=1; push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11 on cycle 4 after first accept, then 0x22, 0x33 back-to-back; occupancy peaks at 3, returns to 0.
- out_ready=0, push 6 items → in_ready drops after 4 accepts, occupancy=4; then raise out_ready → items 1..4 exit in order, items 5,6 accepted and exit.
- Chain holds A,B,C,D in stages 3..0; flush_mask=4'b0100 one cycle (kills B) with out_ready=1 → output sequence A,C,D; B never seen; occupancy decrements by 2 that cycle (A out, B killed).
- Chain full, stall=1 for 3 cycles with in_valid=1, out_ready=1 → no transfers, stage_data unchanged, in_ready=0, out_valid=0; after stall releases, flow resumes with no loss.
- Chain holding 3 items, flush=1 with in_valid=1 → next cycle stage_valid=0, occupancy=0, the in_data of the flush cycle is not accepted.
- Assert rst asynchronously between edges with chain full → stage_valid=0, occupancy=0, stage_data=RESET_DATA immediately, before the next clk edge.
